writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: issue_valid  in  1  scheduler issued an instruction this cycle.
REQ-004 SHALL have ports: issue_rd, issue_rd2  in  7 each  destination register numbers of the issued instruction.
REQ-005 SHALL have ports: wb_req  in  5  per-unit result ready; bit0 alu1, bit1 alu2, bit2 advint, bit3 memunit, bit4 branch.
REQ-006 SHALL have ports: wb_rd  in  35  per-unit destination, 7 bits per unit, unit i at [7i+6:7i].
REQ-007 SHALL have ports: wb_data  in  320  per-unit result, 64 bits per unit, unit i at [64i+63:64i].
REQ-008 SHALL have ports: advint_rd2  in  7, advint_data2  in  64  second advint result.
REQ-009 SHALL have ports: wb_gnt  out  5  one-hot, pulses one cycle when the unit's result is fully written.
REQ-010 SHALL have ports: rf_we  out  1, rf_waddr  out  6, rf_wdata  out  64  register-file write port.
REQ-011 SHALL have ports: reg_busy  out  64  per-register pending-write flags, consumed by the scheduler.

Function
REQ-012 A register number SHALL be "null" when bit 6 is 1 or bits [5:0] are 0; null destinations are never marked busy nor written.
REQ-013 On issue_valid, reg_busy SHALL set, at the next edge, the bits of non-null issue_rd and issue_rd2.
REQ-014 A unit's request SHALL be held stable (wb_req, wb_rd, wb_data, advint_rd2/data2) until its wb_gnt pulse; the arbiter SHALL NOT drop or reorder a held request.
REQ-015 Arbitration SHALL be round-robin over wb_req, starting search one above the last granted unit; after reset the pointer SHALL favour unit 0.
REQ-016 FSM states: IDLE, WB1, WB2.
REQ-017 IDLE/WB1 with any wb_req (excluding the unit granted this cycle) -> WB1: register rf_we=1, rf_waddr=wb_rd[5:0], rf_wdata=wb_data of the winner; rf_we=0 when winner's wb_rd is null.
REQ-018 Winner advint with non-null advint_rd2 -> WB2 next cycle writing advint_rd2/advint_data2; wb_gnt[2] SHALL pulse in the WB2 cycle, not WB1.
REQ-019 Otherwise wb_gnt[winner] SHALL pulse in the WB1 cycle; no req -> IDLE with rf_we=0.
REQ-020 Latency: request sampled at edge N -> rf_we high in cycle N+1 -> busy bit clears at edge ending that write cycle.
REQ-021 Throughput: one register write per cycle, back-to-back grants without idle cycles.
REQ-022 No new winner SHALL be selected during WB2.
REQ-023 Simultaneous set (issue) and clear (writeback) of the same register SHALL leave it busy.
REQ-024 Writing a register not busy SHALL be permitted and leave it clear.

Reset
REQ-025 On rst: state IDLE, rr pointer = unit 4 (so unit 0 wins first), wb_gnt=0, rf_we=0, rf_waddr=0, rf_wdata=0, reg_busy=0.
REQ-026 Reset mid-WB2 SHALL abandon the second write; no wb_gnt pulse after reset release until a new grant.

Structure
REQ-027 Unit index constants (ALU1=0..BRANCH=4), NUM_UNITS=5, null-register test, and FSM state encoding SHALL live in a shared package.
REQ-028 The round-robin selector SHALL be a sub-module rr_arbiter (5 requests, one-hot grant, pointer input).

Verification
REQ-029 Issue rd=7 then alu1 req rd=7 data=0xDEAD -> rf_we, waddr=7, wdata=0xDEAD next cycle, wb_gnt[0] same cycle, reg_busy[7] clear one cycle later.
REQ-030 All five req held continuously, advint rd2 null -> grants 0,1,2,3,4,0 in consecutive cycles.
REQ-031 advint req rd=3 rd2=4 data=1/2 -> write r3=1 then r4=2, wb_gnt[2] only in second cycle, alu1 req waiting granted in third cycle.
REQ-032 issue_valid rd=9 same cycle as write to r9 completes -> reg_busy[9] stays 1.
REQ-033 issue rd=0x40 and rd=0 -> no busy bits set; wb to those -> rf_we=0, wb_gnt pulses.
REQ-034 rst asserted during WB2 -> all outputs zero immediately; after release no wb_gnt without new wb_req.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the writeback arbiter:
// unit indices, FSM encoding and the null-register test.
package writeback_arbiter_pkg;

  localparam int NUM_UNITS = 5;
  localparam int ALU1      = 0;
  localparam int ALU2      = 1;
  localparam int ADVINT    = 2;
  localparam int MEMUNIT   = 3;
  localparam int BRANCH    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB1  = 2'd1,
    WB2  = 2'd2
  } wb_state_t;

  function automatic logic is_null(input logic [6:0] rd);
    return rd[6] || (rd[5:0] == 6'd0);
  endfunction

endpackage

// File: rtl/writeback_arbiter_rr_arbiter.sv
// Round-robin selector: search begins one unit
// above ptr and wraps; grant is one-hot.
module rr_arbiter
  import writeback_arbiter_pkg::*;
(
  input  logic [NUM_UNITS-1:0] req,
  input  logic [2:0]           ptr,
  output logic [NUM_UNITS-1:0] gnt,
  output logic [2:0]           idx,
  output logic                 any
);

  logic [2:0] u;

  always_comb begin
    gnt = '0;
    idx = ptr;
    any = 1'b0;
    u   = '0;
    for (int k = 1; k <= NUM_UNITS; k++) begin
      u = 3'((int'(ptr) + k) % NUM_UNITS);
      if (!any && req[u]) begin
        gnt[u] = 1'b1;
        idx    = u;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: round-robin over five units onto one
// register-file write port, with per-register busy tracking.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         issue_valid,
  input  logic [6:0]   issue_rd,
  input  logic [6:0]   issue_rd2,
  input  logic [4:0]   wb_req,
  input  logic [34:0]  wb_rd,
  input  logic [319:0] wb_data,
  input  logic [6:0]   advint_rd2,
  input  logic [63:0]  advint_data2,
  output logic [4:0]   wb_gnt,
  output logic         rf_we,
  output logic [5:0]   rf_waddr,
  output logic [63:0]  rf_wdata,
  output logic [63:0]  reg_busy
);

  wb_state_t  state;
  logic       pend2;
  logic [2:0] ptr;

  logic [4:0]  req_m;
  logic [4:0]  win_gnt;
  logic [2:0]  win_idx;
  logic        win_any;
  logic [6:0]  win_rd;
  logic [63:0] win_data;
  logic [63:0] set_m;
  logic [63:0] clr_m;

  // A unit still shows its request in its grant cycle.
  assign req_m = wb_req & ~wb_gnt;

  rr_arbiter u_rr (
    .req (req_m),
    .ptr (ptr),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  always_comb begin
    win_rd   = '0;
    win_data = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (win_gnt[i]) begin
        win_rd   = wb_rd[7*i +: 7];
        win_data = wb_data[64*i +: 64];
      end
    end
  end

  always_comb begin
    set_m = '0;
    clr_m = '0;
    if (issue_valid && !is_null(issue_rd))
      set_m[issue_rd[5:0]] = 1'b1;
    if (issue_valid && !is_null(issue_rd2))
      set_m[issue_rd2[5:0]] = 1'b1;
    if (rf_we)
      clr_m[rf_waddr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pend2    <= 1'b0;
      ptr      <= 3'(BRANCH);
      wb_gnt   <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      reg_busy <= '0;
    end else begin
      // Issue wins over a same-cycle clear.
      reg_busy <= (reg_busy & ~clr_m) | set_m;
      if (state == WB1 && pend2) begin
        state    <= WB2;
        pend2    <= 1'b0;
        rf_we    <= !is_null(advint_rd2);
        rf_waddr <= advint_rd2[5:0];
        rf_wdata <= advint_data2;
        wb_gnt   <= 5'(1 << ADVINT);
      end else if (win_any) begin
        state    <= WB1;
        ptr      <= win_idx;
        rf_we    <= !is_null(win_rd);
        rf_waddr <= win_rd[5:0];
        rf_wdata <= win_data;
        if (win_idx == 3'(ADVINT) &&
            !is_null(advint_rd2)) begin
          pend2  <= 1'b1;
          wb_gnt <= '0;
        end else begin
          wb_gnt <= win_gnt;
        end
      end else begin
        state  <= IDLE;
        rf_we  <= 1'b0;
        wb_gnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_writeback_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         issue_valid;
  logic [6:0]   issue_rd;
  logic [6:0]   issue_rd2;
  logic [4:0]   wb_req;
  logic [34:0]  wb_rd;
  logic [319:0] wb_data;
  logic [6:0]   advint_rd2;
  logic [63:0]  advint_data2;
  logic [4:0]   wb_gnt;
  logic         rf_we;
  logic [5:0]   rf_waddr;
  logic [63:0]  rf_wdata;
  logic [63:0]  reg_busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  writeback_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_rd2    (issue_rd2),
    .wb_req       (wb_req),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .advint_rd2   (advint_rd2),
    .advint_data2 (advint_data2),
    .wb_gnt       (wb_gnt),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .reg_busy     (reg_busy)
  );

  function automatic bit tb_null(input logic [6:0] r);
    return (r >= 7'd64) || (r == 7'd0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid  = 1'b0;
    issue_rd     = '0;
    issue_rd2    = '0;
    wb_req       = '0;
    wb_rd        = '0;
    wb_data      = '0;
    advint_rd2   = '0;
    advint_data2 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_unit(input int i, input logic [6:0] rd,
                          input logic [63:0] d);
    wb_req[i]          = 1'b1;
    wb_rd[7*i +: 7]    = rd;
    wb_data[64*i +: 64] = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    issue_valid = 1'b1;
    issue_rd    = 7'd5;
    set_unit(1, 7'd5, 64'h55);
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_total++;
    if (rf_we !== 1'b0) $display("FAIL reset_we got %0b want 0", rf_we);
    else n_pass++;
    n_total++;
    if (wb_gnt !== 5'd0) $display("FAIL reset_gnt got %b want 0", wb_gnt);
    else n_pass++;
    n_total++;
    if (rf_waddr !== 6'd0) $display("FAIL reset_waddr got %0d want 0", rf_waddr);
    else n_pass++;
    n_total++;
    if (rf_wdata !== 64'd0) $display("FAIL reset_wdata got %h want 0", rf_wdata);
    else n_pass++;
    n_total++;
    if (reg_busy !== 64'd0) $display("FAIL reset_busy got %h want 0", reg_busy);
    else n_pass++;
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    issue_valid = 1'b1;
    issue_rd    = 7'd7;
    tick();
    n_total++;
    if (reg_busy[7] !== 1'b1) $display("FAIL basic_set got %b want 1", reg_busy[7]);
    else n_pass++;
    idle_inputs();
    set_unit(0, 7'd7, 64'hDEAD);
    tick();
    n_total++;
    if (rf_we !== 1'b1) $display("FAIL basic_we got %0b want 1", rf_we);
    else n_pass++;
    n_total++;
    if (rf_waddr !== 6'd7) $display("FAIL basic_waddr got %0d want 7", rf_waddr);
    else n_pass++;
    n_total++;
    if (rf_wdata !== 64'hDEAD) $display("FAIL basic_wdata got %h want dead", rf_wdata);
    else n_pass++;
    n_total++;
    if (wb_gnt !== 5'b00001) $display("FAIL basic_gnt got %b want 00001", wb_gnt);
    else n_pass++;
    n_total++;
    if (reg_busy[7] !== 1'b1) $display("FAIL basic_busy_hold got %b want 1", reg_busy[7]);
    else n_pass++;
    idle_inputs();
    tick();
    n_total++;
    if (reg_busy[7] !== 1'b0) $display("FAIL basic_clear got %b want 0", reg_busy[7]);
    else n_pass++;
    n_total++;
    if (rf_we !== 1'b0 || wb_gnt !== 5'd0)
      $display("FAIL basic_idle got we=%0b gnt=%b want 0/0", rf_we, wb_gnt);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 5; i++) set_unit(i, 7'(10 + i), 64'(100 + i));
    for (int k = 0; k < 6; k++) begin
      tick();
      n_total++;
      if (wb_gnt !== 5'(1 << (k % 5)))
        $display("FAIL rr_gnt%0d got %b want %b", k, wb_gnt, 5'(1 << (k % 5)));
      else n_pass++;
      n_total++;
      if (rf_waddr !== 6'(10 + k % 5) || rf_we !== 1'b1)
        $display("FAIL rr_waddr%0d got %0d want %0d", k, rf_waddr, 10 + k % 5);
      else n_pass++;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_advint_pair();
    do_reset();
    set_unit(2, 7'd3, 64'd1);
    advint_rd2   = 7'd4;
    advint_data2 = 64'd2;
    tick();
    n_total++;
    if (rf_we !== 1'b1 || rf_waddr !== 6'd3 || rf_wdata !== 64'd1)
      $display("FAIL adv_first got we=%0b a=%0d d=%0d want 1/3/1", rf_we, rf_waddr, rf_wdata);
    else n_pass++;
    n_total++;
    if (wb_gnt !== 5'd0) $display("FAIL adv_first_gnt got %b want 0", wb_gnt);
    else n_pass++;
    set_unit(0, 7'd5, 64'd7);
    tick();
    n_total++;
    if (rf_we !== 1'b1 || rf_waddr !== 6'd4 || rf_wdata !== 64'd2)
      $display("FAIL adv_second got we=%0b a=%0d d=%0d want 1/4/2", rf_we, rf_waddr, rf_wdata);
    else n_pass++;
    n_total++;
    if (wb_gnt !== 5'b00100) $display("FAIL adv_second_gnt got %b want 00100", wb_gnt);
    else n_pass++;
    wb_req[2] = 1'b0;
    tick();
    n_total++;
    if (rf_we !== 1'b1 || rf_waddr !== 6'd5 || rf_wdata !== 64'd7)
      $display("FAIL adv_alu1 got we=%0b a=%0d d=%0d want 1/5/7", rf_we, rf_waddr, rf_wdata);
    else n_pass++;
    n_total++;
    if (wb_gnt !== 5'b00001) $display("FAIL adv_alu1_gnt got %b want 00001", wb_gnt);
    else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_set_clear();
    do_reset();
    issue_valid = 1'b1;
    issue_rd    = 7'd9;
    tick();
    idle_inputs();
    set_unit(0, 7'd9, 64'h99);
    tick();
    n_total++;
    if (rf_we !== 1'b1 || rf_waddr !== 6'd9)
      $display("FAIL sc_write got we=%0b a=%0d want 1/9", rf_we, rf_waddr);
    else n_pass++;
    idle_inputs();
    issue_valid = 1'b1;
    issue_rd    = 7'd9;
    tick();
    n_total++;
    if (reg_busy[9] !== 1'b1) $display("FAIL sc_busy got %b want 1", reg_busy[9]);
    else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_null();
    do_reset();
    issue_valid = 1'b1;
    issue_rd    = 7'h40;
    issue_rd2   = 7'h00;
    tick();
    n_total++;
    if (reg_busy !== 64'd0) $display("FAIL null_busy got %h want 0", reg_busy);
    else n_pass++;
    idle_inputs();
    set_unit(1, 7'h40, 64'h1);
    tick();
    n_total++;
    if (rf_we !== 1'b0 || wb_gnt !== 5'b00010)
      $display("FAIL null_alu2 got we=%0b gnt=%b want 0/00010", rf_we, wb_gnt);
    else n_pass++;
    idle_inputs();
    set_unit(4, 7'h00, 64'h2);
    tick();
    n_total++;
    if (rf_we !== 1'b0 || wb_gnt !== 5'b10000)
      $display("FAIL null_branch got we=%0b gnt=%b want 0/10000", rf_we, wb_gnt);
    else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_wb2();
    do_reset();
    set_unit(2, 7'd3, 64'd1);
    advint_rd2   = 7'd4;
    advint_data2 = 64'd2;
    tick();
    tick();
    n_total++;
    if (wb_gnt !== 5'b00100) $display("FAIL rwb2_pre got %b want 00100", wb_gnt);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (rf_we !== 1'b0 || wb_gnt !== 5'd0 || rf_waddr !== 6'd0 ||
        rf_wdata !== 64'd0 || reg_busy !== 64'd0)
      $display("FAIL rwb2_zero got we=%0b gnt=%b a=%0d d=%h busy=%h want all 0",
               rf_we, wb_gnt, rf_waddr, rf_wdata, reg_busy);
    else n_pass++;
    idle_inputs();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++;
      if (wb_gnt !== 5'd0 || rf_we !== 1'b0)
        $display("FAIL rwb2_quiet%0d got gnt=%b we=%0b want 0/0", k, wb_gnt, rf_we);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [4:0]  pend;
    logic [6:0]  urd[5];
    logic [63:0] udat[5];
    logic [6:0]  urd2;
    logic [63:0] udat2;
    logic        e_we;
    logic [5:0]  e_addr;
    logic [63:0] e_data;
    logic [4:0]  e_gnt;
    logic [63:0] e_busy;
    logic [63:0] nb;
    logic [4:0]  cand;
    int          last;
    int          w;
    int          u;
    bit          second;
    do_reset();
    pend = '0;
    for (int i = 0; i < 5; i++) begin
      urd[i]  = '0;
      udat[i] = '0;
    end
    urd2 = '0; udat2 = '0;
    e_we = 1'b0; e_addr = '0; e_data = '0;
    e_gnt = '0; e_busy = '0;
    last = 4; second = 1'b0;
    for (int c = 0; c < 400; c++) begin
      n_total++;
      if (rf_we !== e_we) $display("FAIL rnd_we c%0d got %0b want %0b", c, rf_we, e_we);
      else n_pass++;
      n_total++;
      if (wb_gnt !== e_gnt) $display("FAIL rnd_gnt c%0d got %b want %b", c, wb_gnt, e_gnt);
      else n_pass++;
      n_total++;
      if (reg_busy !== e_busy)
        $display("FAIL rnd_busy c%0d got %h want %h", c, reg_busy, e_busy);
      else n_pass++;
      if (e_we) begin
        n_total++;
        if (rf_waddr !== e_addr || rf_wdata !== e_data)
          $display("FAIL rnd_wr c%0d got %0d/%h want %0d/%h",
                   c, rf_waddr, rf_wdata, e_addr, e_data);
        else n_pass++;
      end
      for (int i = 0; i < 5; i++) begin
        if (e_gnt[i]) pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          urd[i]  = 7'($urandom_range(0, 127));
          udat[i] = {$urandom, $urandom};
          if (i == 2) begin
            urd2  = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 127)) : 7'd0;
            udat2 = {$urandom, $urandom};
          end
        end
      end
      wb_req = pend;
      for (int i = 0; i < 5; i++) begin
        wb_rd[7*i +: 7]     = urd[i];
        wb_data[64*i +: 64] = udat[i];
      end
      advint_rd2   = urd2;
      advint_data2 = udat2;
      issue_valid  = ($urandom_range(0, 1) == 1);
      issue_rd     = 7'($urandom_range(0, 127));
      issue_rd2    = 7'($urandom_range(0, 127));
      nb = e_busy;
      if (e_we) nb[e_addr] = 1'b0;
      if (issue_valid && !tb_null(issue_rd))  nb[issue_rd[5:0]]  = 1'b1;
      if (issue_valid && !tb_null(issue_rd2)) nb[issue_rd2[5:0]] = 1'b1;
      if (second) begin
        e_we   = !tb_null(urd2);
        e_addr = urd2[5:0];
        e_data = udat2;
        e_gnt  = 5'b00100;
        second = 1'b0;
      end else begin
        cand = pend & ~e_gnt;
        w = -1;
        for (int k = 1; k <= 5; k++) begin
          u = (last + k) % 5;
          if (w < 0 && cand[u]) w = u;
        end
        if (w < 0) begin
          e_we  = 1'b0;
          e_gnt = '0;
        end else begin
          e_we   = !tb_null(urd[w]);
          e_addr = urd[w][5:0];
          e_data = udat[w];
          last   = w;
          if (w == 2 && !tb_null(urd2)) begin
            second = 1'b1;
            e_gnt  = '0;
          end else begin
            e_gnt = 5'(1 << w);
          end
        end
      end
      e_busy = nb;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    #2;
    test_reset();
    test_basic();
    test_round_robin();
    test_advint_pair();
    test_set_clear();
    test_null();
    test_reset_wb2();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
